// File: rtl/normalizer_pkg.sv
// normalizer_pkg
//   Shared datapath definitions for the leading-zero normalizer and the
//   blocks it is paired with.
//   - normState_e      : normalizer controller states (IDLE, SHIFT, DONE)
//   - NORM_WIDTH       : default datapath width
//   - SHIFT_CTRL_*     : shift-unit control codes, so the control unit can
//                        route the normalizer's shamt straight into the
//                        shift unit and undo a normalization.
package normalizer_pkg;

  localparam int NORM_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } normState_e;

  localparam logic [1:0] SHIFT_CTRL_PASS = 2'b00;
  localparam logic [1:0] SHIFT_CTRL_LEFT = 2'b01;
  localparam logic [1:0] SHIFT_CTRL_LSR  = 2'b11;

endpackage : normalizer_pkg

// File: rtl/normalizer.sv
// normalizer
//   Multi-cycle leading-zero normalizer. On an accepted start the operand is
//   shifted left one bit per clock until its MSB is set (or it is found to be
//   zero); the normalized word and the shift amount are then held until the
//   next accepted start.
//
//   Ports
//     clk    in   1      clock, rising edge
//     rst    in   1      asynchronous active-high reset
//     start  in   1      request, sampled only in IDLE or DONE
//     data   in   WIDTH  operand, sampled with start
//     busy   out  1      high while shifting
//     done   out  1      one-cycle completion pulse
//     out    out  WIDTH  normalized word
//     shamt  out  CNT_W  leading-zero count (0..WIDTH), zero-extended
//     zero   out  1      operand was all zeros
module normalizer
  import normalizer_pkg::*;
#(
  parameter int WIDTH = NORM_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] shamt,
  output logic             zero
);

  normState_e       state_q, state_d;
  logic [WIDTH-1:0] work_q,  work_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic [CNT_W-1:0] shamt_q, shamt_d;
  logic             zero_q,  zero_d;

  // Register bank. Reset abandons any in-flight operation and clears the
  // held result as well, so no stale value survives a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      shamt_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      shamt_q <= shamt_d;
      zero_q  <= zero_d;
    end
  end

  // Next-state logic. DONE behaves like IDLE for accepting a new request,
  // which gives back-to-back operation without an idle bubble. The result
  // registers only change on the DONE entry edge.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    shamt_d = shamt_q;
    zero_d  = zero_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          work_d  = data;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (work_q == '0) begin
          out_d   = '0;
          shamt_d = CNT_W'(WIDTH);
          zero_d  = 1'b1;
          state_d = ST_DONE;
        end else if (work_q[WIDTH-1]) begin
          out_d   = work_q;
          shamt_d = cnt_q;
          zero_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          // The bit shifted out is known to be zero here, and the count
          // cannot pass WIDTH-1 before the MSB becomes set.
          work_d  = {work_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs decode directly from the state register.
  always_comb begin
    busy = (state_q == ST_SHIFT);
    done = (state_q == ST_DONE);
  end

  assign out   = out_q;
  assign shamt = shamt_q;
  assign zero  = zero_q;

endmodule : normalizer

// File: doc/normalizer.md
# normalizer

Multi-cycle leading-zero normalizer for the 16-bit datapath, the inverse of the shift unit: given a data word, it finds the left-shift amount that brings the most-significant set bit to bit 15, and returns both the normalized word and that amount. It shifts one bit per clock under a start/done handshake. Its `shamt` output feeds the shift unit's `shamt` input directly. Downstream uses are normalize-style instructions and count-leading-zeros.

## Interface
- `WIDTH`, default 16: data width; must be a power of two ≥ 2.
- `CNT_W`, default 16: width of the `shamt` output, matching the shift unit's `shamt` port.
- `clk`, in, 1: the single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `start`, in, 1: request; sampled only in IDLE or DONE.
- `data`, in, WIDTH: operand; sampled on the edge that accepts `start`.
- `busy`, out, 1: high while in SHIFT.
- `done`, out, 1: one-cycle pulse, high in DONE.
- `out`, out, WIDTH: normalized word; held until the next accepted `start`.
- `shamt`, out, CNT_W: count of leading zeros (0…WIDTH), zero-extended; held like `out`.
- `zero`, out, 1: operand was all zeros; held like `out`.

## Operation
- States:
  - IDLE: reset state.
  - SHIFT: one-bit left shift per cycle.
  - DONE: single cycle.
- IDLE/DONE with `start`=1:
  - Latch `data` into the working register.
  - Clear the count.
  - Go to SHIFT.
- IDLE/DONE with `start`=0: go or stay in IDLE. Outputs are not cleared.
- SHIFT, per edge:
  - Working register == 0: `out`=0, `shamt`=WIDTH, `zero`=1; go to DONE.
  - Working register bit WIDTH-1 set: `out`=register, `shamt`=count, `zero`=0; go to DONE.
  - Otherwise: register <<= 1, filling with 0; count += 1; stay in SHIFT.
- `start` during SHIFT is ignored; the in-flight operation is not disturbed.
- Invariant for nonzero data: `out` == `data` << `shamt`, truncated to WIDTH, and `out` >> `shamt` == `data`.
- The count never exceeds WIDTH-1 in SHIFT. The shifted-out bit is always 0, so no overflow handling is needed.

## Timing
- Reset, asynchronous: state=IDLE, `busy`=0, `done`=0, `out`=0, `shamt`=0, `zero`=0. Takes effect immediately, including mid-SHIFT. The operation is abandoned with no `done`.
- Let edge 0 be the edge that accepts `start`, and k the number of leading zeros of a nonzero operand.
  - DONE is entered at edge k+1.
  - `done` is high for the cycle after edge k+1.
  - Latency range: 1 cycle (bit 15 set) to WIDTH cycles (`data`=1).
- A zero operand enters DONE at edge 1.
- `busy` is high from edge 0 until the DONE entry edge. `busy` and `done` are never high together.
- `out`, `shamt` and `zero` update on the DONE entry edge and are valid while `done` is high and afterwards.
- Back-to-back: `start` high during the DONE cycle is accepted at that edge. The next cycle is SHIFT, with no idle bubble.

## Structure
- The shared datapath package holds:
  - the state encoding (IDLE, SHIFT, DONE);
  - the default WIDTH constant;
  - the shift-unit control codes (pass 2'b00, left 2'b01, logical right 2'b11), so the control unit and the bench can pair this block with the shift unit.
- Single flat module: a state register, a working shift register and a count register. No sub-module.
- The bench instantiates the existing shift unit as the round-trip checker.

## Test plan
- `data`=16'h8000 → `done` in the cycle after edge 1; `out`=16'h8000, `shamt`=0, `zero`=0.
- `data`=16'h0001 → `busy` for 16 cycles, then `done`; `out`=16'h8000, `shamt`=15.
- `data`=16'h0000 → `done` in the cycle after edge 1; `out`=0, `shamt`=16, `zero`=1.
- `data`=16'h00F3 → `out`=16'hF300, `shamt`=8; shift unit with control 2'b11 and `shamt`=8 on `out` returns 16'h00F3.
- `data`=16'h0010 accepted, then `start` with 16'hFFFF on cycle 3 → ignored; result `out`=16'h8000, `shamt`=11. Repeat and assert `rst` on cycle 5 → `busy`, `done`, `out`, `shamt` and `zero` all 0 immediately; no `done` follows.
- 16'h4000, then `start` held during its `done` cycle with 16'h0400 → second result `shamt`=5; no idle cycle between the runs.
